microseq_ctrl: RTL and testbench
================================

Name: microseq_ctrl

Overview:
- Microprogram sequencer for the control store: the decode ROM (4-bit address, 8-bit data) and control ROMs A and B (8-bit address, 16-bit data each).
- Accepts an 8-bit instruction and maps its opcode through the decode ROM to a microroutine start address.
- Steps a micro-PC through ROMs A/B and drives the 28-bit control word to the datapath until the microroutine signals completion.

Parameters:
- OPC_W, 4, opcode width / decode ROM address width
- UADDR_W, 8, micro-PC and control ROM address width
- CW_W, 16, width of each control ROM word
- CTRL_W, 28, datapath control-signal width
- WDOG_LIMIT, 64, max micro-steps per instruction (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instruction  in  8  opcode in [7:4]; [3:0] ignored by this block
- instr_ready  out  1  block can accept an instruction
- flag_z  in  1  datapath zero flag, sampled in EXEC
- ext_ready  in  1  external completion for WAIT micro-op
- rom_en  out  1  chip-select shared by all three ROMs
- decode_address  out  4  decode ROM address (registered)
- decode_data  in  8  microroutine start address
- ctrl_a_address  out  8  control ROM A address (registered)
- ctrl_b_address  out  8  control ROM B address (registered, always equal to ctrl_a_address)
- ctrl_a_data  in  16  control word A
- ctrl_b_data  in  16  control word B
- ctrl_signals  out  28  datapath controls
- busy  out  1  instruction in progress
- illegal_uop  out  1  one-cycle pulse on reserved sequence op

Behaviour:
- ROM timing
  - ROMs are synchronous: data is valid the cycle after the cycle in which rom_en=1 with a stable address.
- Microword format
  - ctrl_signals = {ctrl_b_data[11:0], ctrl_a_data[15:0]}.
  - seq = ctrl_b_data[15:12].
- States and transitions
  - IDLE: instr_ready=1. On instr_valid, latch decode_address=instruction[7:4] and go to DEC.
  - DEC: rom_en=1; go to LOAD.
  - LOAD: upc <= decode_data; go to UFETCH.
  - UFETCH: ctrl_a/b_address = upc, rom_en=1; go to EXEC.
  - EXEC: ctrl_signals driven from ROM data; seq evaluated.
- Timing
  - ctrl_signals = 0 in every state except EXEC.
  - First EXEC is 4 cycles after the accept cycle.
  - Each further microinstruction takes 2 cycles (UFETCH+EXEC).
- seq ops (evaluated in EXEC)
  - 0 CONT: upc <= upc+1, go to UFETCH.
  - 1 DONE: go to IDLE.
  - 2 BRZ: upc <= upc + (flag_z ? 2 : 1), go to UFETCH.
  - 3 WAIT: stay in EXEC holding ctrl_signals while ext_ready=0; when ext_ready=1, behave as CONT.
  - 4-15 reserved: behave as DONE and pulse illegal_uop for 1 cycle.
- upc arithmetic is modulo 256: 255+1 -> 0, 255+2 -> 1, 254+2 -> 0. No error is flagged on wrap.
- busy = (state != IDLE).
- instr_valid outside IDLE is ignored. The instruction is not buffered; the source holds it until instr_ready.
- DONE followed immediately by instr_valid: accepted in the IDLE cycle, so there is one idle cycle between instructions.
- Reset (rst_n=0 at a clock edge), including mid-instruction:
  - state=IDLE, upc=0, all addresses 0, rom_en=0, ctrl_signals=0, illegal_uop=0.
  - instr_ready=0 while rst_n=0.
  - In-flight microroutine is abandoned.

Optional Feature:
- Macro: MICROSEQ_WDOG_EN
- With the macro defined:
  - Adds output port wdog_trip (1 bit) and an internal step counter.
  - Counter clears on accept and increments on each EXEC exit (WAIT cycles not counted).
  - Reaching WDOG_LIMIT forces IDLE (ctrl_signals=0 next cycle) and pulses wdog_trip for 1 cycle.
  - Reset clears the counter and wdog_trip.
- Without the macro: no port, no counter; a looping microprogram runs indefinitely.

Decomposition:
- Package microseq_pkg holds:
  - state enum {IDLE, DEC, LOAD, UFETCH, EXEC}
  - seq-op constants SEQ_CONT=0, SEQ_DONE=1, SEQ_BRZ=2, SEQ_WAIT=3
  - field positions SEQ_MSB=15, SEQ_LSB=12
  - width constants
- One natural sub-module, microseq_next_addr: combinational upc/next-state computation from seq, flag_z and ext_ready. The FSM and registers stay in the top.

Test Plan:
- Decode 0x3 -> 0x40, uwords at 0x40 CONT and 0x41 DONE; send instruction 0x3A:
  - instr_ready drops next cycle, decode_address=3.
  - ctrl_signals nonzero exactly in cycles 4 and 6 after accept; busy falls after 0x41.
- BRZ at 0x10 with flag_z=1 -> next ctrl_a_address=0x12; repeat with flag_z=0 -> 0x11.
- WAIT at 0x20, ext_ready low 5 cycles -> ctrl_signals held constant 5 cycles; next fetch at 0x21 one cycle after ext_ready=1.
- upc=0xFF with CONT -> ctrl_a_address=0x00; BRZ at 0xFE with flag_z=1 -> 0x00.
- seq=0x7 -> illegal_uop high exactly 1 cycle, return to IDLE, instr_ready=1 next cycle.
- rst_n=0 during EXEC -> next cycle all outputs 0, instr_ready=0; after release, instr_ready=1 and a new instruction executes normally.
- With MICROSEQ_WDOG_EN: self-loop microroutine -> wdog_trip pulses after 64 steps, returns to IDLE.

Source files
------------

// File: rtl/microseq_ctrl_pkg.sv
// Shared types and constants for the microprogram sequencer.
package microseq_pkg;
   localparam int OPC_W      = 4;
   localparam int UADDR_W    = 8;
   localparam int CW_W       = 16;
   localparam int CTRL_W     = 28;
   localparam int INSTR_W    = 8;
   localparam int SEQ_W      = 4;
   localparam int WDOG_LIMIT = 64;

   // Sequence-op field inside control word B
   localparam int SEQ_MSB = 15;
   localparam int SEQ_LSB = 12;

   localparam logic [SEQ_W-1:0] SEQ_CONT = 4'd0;
   localparam logic [SEQ_W-1:0] SEQ_DONE = 4'd1;
   localparam logic [SEQ_W-1:0] SEQ_BRZ  = 4'd2;
   localparam logic [SEQ_W-1:0] SEQ_WAIT = 4'd3;

   typedef enum logic [2:0] {IDLE, DEC, LOAD, UFETCH, EXEC} state_t;

   // What the sequencer does when leaving (or staying in) EXEC
   typedef enum logic [1:0] {ACT_FETCH, ACT_HOLD, ACT_DONE} act_t;
endpackage

// File: rtl/microseq_ctrl_if.sv
// Instruction handshake, control-store ROM bus and datapath control bundle.
interface microseq_ctrl_if;
   logic                                instr_valid;
   logic [microseq_pkg::INSTR_W-1:0]    instruction;
   logic                                instr_ready;
   logic                                flag_z;
   logic                                ext_ready;
   logic                                rom_en;
   logic [microseq_pkg::OPC_W-1:0]      decode_address;
   logic [microseq_pkg::UADDR_W-1:0]    decode_data;
   logic [microseq_pkg::UADDR_W-1:0]    ctrl_a_address;
   logic [microseq_pkg::UADDR_W-1:0]    ctrl_b_address;
   logic [microseq_pkg::CW_W-1:0]       ctrl_a_data;
   logic [microseq_pkg::CW_W-1:0]       ctrl_b_data;
   logic [microseq_pkg::CTRL_W-1:0]     ctrl_signals;
   logic                                busy;
   logic                                illegal_uop;

   // Sequencer side
   modport master (
      input  instr_valid, instruction, flag_z, ext_ready,
             decode_data, ctrl_a_data, ctrl_b_data,
      output instr_ready, rom_en, decode_address, ctrl_a_address,
             ctrl_b_address, ctrl_signals, busy, illegal_uop
   );

   // Instruction source / ROMs / datapath side
   modport slave (
      output instr_valid, instruction, flag_z, ext_ready,
             decode_data, ctrl_a_data, ctrl_b_data,
      input  instr_ready, rom_en, decode_address, ctrl_a_address,
             ctrl_b_address, ctrl_signals, busy, illegal_uop
   );
endinterface

// File: rtl/microseq_ctrl_next_addr.sv
// Combinational next micro-PC and EXEC action from the current sequence op.
module microseq_next_addr
   import microseq_pkg::*;
(
   input  logic [UADDR_W-1:0] i_upc,
   input  logic [SEQ_W-1:0]   i_seq,
   input  logic               i_flag_z,
   input  logic               i_ext_ready,
   output logic [UADDR_W-1:0] o_upc_next,
   output act_t               o_act,
   output logic               o_illegal
);
   // Decode seq op; micro-PC arithmetic wraps modulo 2**UADDR_W
   always_comb begin
      o_upc_next = i_upc + UADDR_W'(1);
      o_act      = ACT_FETCH;
      o_illegal  = 1'b0;
      case (i_seq)
         SEQ_CONT: o_act = ACT_FETCH;
         SEQ_DONE: o_act = ACT_DONE;
         SEQ_BRZ:  if (i_flag_z) o_upc_next = i_upc + UADDR_W'(2);
         SEQ_WAIT: if (!i_ext_ready) o_act = ACT_HOLD;
         default: begin
            o_act     = ACT_DONE;
            o_illegal = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: opcode -> decode ROM -> micro-PC walk over ROMs A/B.
// Optional step watchdog enabled by defining MICROSEQ_WDOG_EN.
module microseq_ctrl
   import microseq_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   microseq_ctrl_if.master bus
`ifdef MICROSEQ_WDOG_EN
   ,
   output logic            wdog_trip
`endif
);
   state_t               r_state;
   logic [UADDR_W-1:0]   r_upc;
   logic [OPC_W-1:0]     r_decode_address;
   logic [UADDR_W-1:0]   r_ctrl_address;
   logic                 r_rom_en;
   logic                 r_illegal_uop;
   logic [UADDR_W-1:0]   w_upc_next;
   act_t                 w_act;
   logic                 w_illegal;
`ifdef MICROSEQ_WDOG_EN
   localparam int STEP_W = $clog2(WDOG_LIMIT + 1);
   logic [STEP_W-1:0]    r_step_cnt;
   logic                 r_wdog_trip;
`endif

   microseq_next_addr u_next_addr (
      .i_upc       (r_upc),
      .i_seq       (bus.ctrl_b_data[SEQ_MSB:SEQ_LSB]),
      .i_flag_z    (bus.flag_z),
      .i_ext_ready (bus.ext_ready),
      .o_upc_next  (w_upc_next),
      .o_act       (w_act),
      .o_illegal   (w_illegal)
   );

   // Sequencer FSM with registered ROM addresses, chip-select and pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_upc            <= '0;
         r_decode_address <= '0;
         r_ctrl_address   <= '0;
         r_rom_en         <= 1'b0;
         r_illegal_uop    <= 1'b0;
`ifdef MICROSEQ_WDOG_EN
         r_step_cnt       <= '0;
         r_wdog_trip      <= 1'b0;
`endif
      end else begin
         r_rom_en      <= 1'b0;
         r_illegal_uop <= 1'b0;
`ifdef MICROSEQ_WDOG_EN
         r_wdog_trip   <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (bus.instr_valid) begin
                  r_decode_address <= bus.instruction[INSTR_W-1:INSTR_W-OPC_W];
                  r_rom_en         <= 1'b1;
                  r_state          <= DEC;
`ifdef MICROSEQ_WDOG_EN
                  r_step_cnt       <= '0;
`endif
               end
            end
            DEC: r_state <= LOAD;
            LOAD: begin
               // Start address goes straight onto the control ROM address bus
               r_upc          <= bus.decode_data;
               r_ctrl_address <= bus.decode_data;
               r_rom_en       <= 1'b1;
               r_state        <= UFETCH;
            end
            UFETCH: r_state <= EXEC;
            EXEC: begin
               case (w_act)
                  ACT_HOLD: r_state <= EXEC;
                  ACT_FETCH: begin
                     r_upc          <= w_upc_next;
                     r_ctrl_address <= w_upc_next;
                     r_rom_en       <= 1'b1;
                     r_state        <= UFETCH;
                  end
                  default: begin
                     r_illegal_uop <= w_illegal;
                     r_state       <= IDLE;
                  end
               endcase
`ifdef MICROSEQ_WDOG_EN
               // Count EXEC exits only; the limit-th exit aborts the routine
               if (w_act != ACT_HOLD) begin
                  r_step_cnt <= r_step_cnt + STEP_W'(1);
                  if (r_step_cnt == STEP_W'(WDOG_LIMIT - 1)) begin
                     r_state     <= IDLE;
                     r_rom_en    <= 1'b0;
                     r_wdog_trip <= 1'b1;
                  end
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.instr_ready    = rst_n && (r_state == IDLE);
   assign bus.busy           = (r_state != IDLE);
   assign bus.rom_en         = r_rom_en;
   assign bus.decode_address = r_decode_address;
   assign bus.ctrl_a_address = r_ctrl_address;
   assign bus.ctrl_b_address = r_ctrl_address;
   assign bus.illegal_uop    = r_illegal_uop;
   // ROM data is only meaningful in EXEC; everywhere else the datapath sees zero
   assign bus.ctrl_signals   = (r_state == EXEC) ?
                               {bus.ctrl_b_data[CTRL_W-CW_W-1:0], bus.ctrl_a_data} : '0;
`ifdef MICROSEQ_WDOG_EN
   assign wdog_trip          = r_wdog_trip;
`endif
endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed testbench for microseq_ctrl with behavioural synchronous ROMs.
module tb_microseq_ctrl;
   import microseq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   microseq_ctrl_if bus();
`ifdef MICROSEQ_WDOG_EN
   logic wdog_trip;
`endif

   microseq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef MICROSEQ_WDOG_EN
      ,
      .wdog_trip (wdog_trip)
`endif
   );

   logic [7:0]  drom [16];
   logic [15:0] roma [256];
   logic [15:0] romb [256];

   // Synchronous ROMs: output updates only when chip-select is high
   always @(posedge clk) begin
      if (bus.rom_en) begin
         bus.decode_data <= drom[bus.decode_address];
         bus.ctrl_a_data <= roma[bus.ctrl_a_address];
         bus.ctrl_b_data <= romb[bus.ctrl_b_address];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] a, input logic [3:0] seq, input logic [27:0] cw);
      roma[a] = cw[15:0];
      romb[a] = {seq, cw[27:16]};
   endtask

   // Accept an instruction and advance to its first EXEC cycle (4 after accept)
   task automatic issue(input logic [7:0] ins);
      $display("txn instr=0x%02h flag_z=%0b ext_ready=%0b", ins, bus.flag_z, bus.ext_ready);
      bus.instr_valid = 1'b1;
      bus.instruction = ins;
      tick();
      bus.instr_valid = 1'b0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.instruction = 8'h00;
      bus.flag_z      = 1'b0;
      bus.ext_ready   = 1'b0;
      bus.decode_data = 8'h00;
      bus.ctrl_a_data = 16'h0;
      bus.ctrl_b_data = 16'h0;
      for (int i = 0; i < 16; i++) drom[i] = 8'h00;
      for (int i = 0; i < 256; i++) put(8'(i), SEQ_DONE, 28'h0);
      drom[3] = 8'h40; put(8'h40, SEQ_CONT, 28'h1234567); put(8'h41, SEQ_DONE, 28'hABCDEF1);
      drom[1] = 8'h10; put(8'h10, SEQ_BRZ, 28'h10);
      put(8'h11, SEQ_DONE, 28'h11); put(8'h12, SEQ_DONE, 28'h12);
      drom[2] = 8'h20; put(8'h20, SEQ_WAIT, 28'h2222222); put(8'h21, SEQ_DONE, 28'h21);
      drom[4] = 8'hFF; put(8'hFF, SEQ_CONT, 28'hFF); put(8'h00, SEQ_DONE, 28'h5);
      drom[5] = 8'hFE; put(8'hFE, SEQ_BRZ, 28'hFE);
      drom[7] = 8'h30; put(8'h30, 4'h7, 28'h30);
      drom[8] = 8'h60;
      for (int i = 8'h60; i < 8'hA0; i++) put(8'(i), SEQ_CONT, 28'(i));

      // Reset state
      tick(); tick(); tick();
      chk("rst_ready", 32'(bus.instr_ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rom_en", 32'(bus.rom_en), 0);
      chk("rst_ctrl", 32'(bus.ctrl_signals), 0);
      chk("rst_caddr", 32'(bus.ctrl_a_address), 0);
      chk("rst_daddr", 32'(bus.decode_address), 0);
      chk("rst_illegal", 32'(bus.illegal_uop), 0);
`ifdef MICROSEQ_WDOG_EN
      chk("rst_wdog", 32'(wdog_trip), 0);
`endif
      rst_n = 1'b1;
      #1;
      chk("idle_ready", 32'(bus.instr_ready), 1);

      // CONT then DONE, cycle by cycle
      $display("txn instr=0x3a cycle-accurate");
      bus.instr_valid = 1'b1; bus.instruction = 8'h3A;
      tick(); bus.instr_valid = 1'b0;
      chk("c1_ready", 32'(bus.instr_ready), 0);
      chk("c1_daddr", 32'(bus.decode_address), 3);
      chk("c1_rom_en", 32'(bus.rom_en), 1);
      chk("c1_ctrl", 32'(bus.ctrl_signals), 0);
      tick();
      chk("c2_ctrl", 32'(bus.ctrl_signals), 0);
      tick();
      chk("c3_caddr", 32'(bus.ctrl_a_address), 32'h40);
      chk("c3_cbaddr", 32'(bus.ctrl_b_address), 32'h40);
      chk("c3_ctrl", 32'(bus.ctrl_signals), 0);
      tick();
      chk("c4_ctrl", 32'(bus.ctrl_signals), 32'h1234567);
      tick();
      chk("c5_ctrl", 32'(bus.ctrl_signals), 0);
      chk("c5_caddr", 32'(bus.ctrl_a_address), 32'h41);
      tick();
      chk("c6_ctrl", 32'(bus.ctrl_signals), 32'hABCDEF1);
      chk("c6_busy", 32'(bus.busy), 1);
      tick();
      chk("c7_busy", 32'(bus.busy), 0);
      chk("c7_ctrl", 32'(bus.ctrl_signals), 0);
      chk("c7_ready", 32'(bus.instr_ready), 1);
      // Back-to-back: accepted in the first IDLE cycle
      issue(8'h3A);
      chk("b2b_ctrl", 32'(bus.ctrl_signals), 32'h1234567);
      tick(); tick();
      chk("b2b_ctrl2", 32'(bus.ctrl_signals), 32'hABCDEF1);
      tick();
      chk("b2b_idle", 32'(bus.busy), 0);

      // BRZ taken / not taken
      bus.flag_z = 1'b1;
      issue(8'h10);
      chk("brz1_ctrl", 32'(bus.ctrl_signals), 32'h10);
      tick();
      chk("brz1_addr", 32'(bus.ctrl_a_address), 32'h12);
      tick();
      chk("brz1_ctrl2", 32'(bus.ctrl_signals), 32'h12);
      tick();
      bus.flag_z = 1'b0;
      issue(8'h10);
      tick();
      chk("brz0_addr", 32'(bus.ctrl_a_address), 32'h11);
      tick();
      chk("brz0_ctrl2", 32'(bus.ctrl_signals), 32'h11);
      tick();

      // WAIT holds while ext_ready=0; new instr_valid ignored while busy
      issue(8'h20);
      for (int i = 0; i < 5; i++) begin
         chk("wait_hold", 32'(bus.ctrl_signals), 32'h2222222);
         if (i == 1) begin bus.instr_valid = 1'b1; bus.instruction = 8'h7A; end
         tick();
         bus.instr_valid = 1'b0;
      end
      chk("wait_ignore", 32'(bus.decode_address), 2);
      chk("wait_hold5", 32'(bus.ctrl_signals), 32'h2222222);
      bus.ext_ready = 1'b1;
      tick();
      bus.ext_ready = 1'b0;
      chk("wait_next", 32'(bus.ctrl_a_address), 32'h21);
      chk("wait_ctrl0", 32'(bus.ctrl_signals), 0);
      tick();
      chk("wait_ctrl2", 32'(bus.ctrl_signals), 32'h21);
      tick();

      // micro-PC wrap
      issue(8'h40);
      tick();
      chk("wrap_cont", 32'(bus.ctrl_a_address), 0);
      tick();
      chk("wrap_ctrl", 32'(bus.ctrl_signals), 5);
      tick();
      bus.flag_z = 1'b1;
      issue(8'h50);
      tick();
      chk("wrap_brz", 32'(bus.ctrl_a_address), 0);
      tick(); tick();
      bus.flag_z = 1'b0;

      // Reserved seq op
      issue(8'h70);
      chk("ill_pre", 32'(bus.illegal_uop), 0);
      chk("ill_ctrl", 32'(bus.ctrl_signals), 32'h30);
      tick();
      chk("ill_pulse", 32'(bus.illegal_uop), 1);
      chk("ill_idle", 32'(bus.busy), 0);
      chk("ill_ready", 32'(bus.instr_ready), 1);
      tick();
      chk("ill_clear", 32'(bus.illegal_uop), 0);

      // Reset during EXEC
      issue(8'h20);
      tick();
      rst_n = 1'b0;
      tick();
      chk("mrst_ctrl", 32'(bus.ctrl_signals), 0);
      chk("mrst_rom_en", 32'(bus.rom_en), 0);
      chk("mrst_caddr", 32'(bus.ctrl_a_address), 0);
      chk("mrst_daddr", 32'(bus.decode_address), 0);
      chk("mrst_busy", 32'(bus.busy), 0);
      chk("mrst_ready", 32'(bus.instr_ready), 0);
      rst_n = 1'b1;
      #1;
      chk("mrst_rel", 32'(bus.instr_ready), 1);
      issue(8'h3A);
      chk("mrst_run", 32'(bus.ctrl_signals), 32'h1234567);
      tick(); tick();
      chk("mrst_run2", 32'(bus.ctrl_signals), 32'hABCDEF1);
      tick();
      chk("mrst_done", 32'(bus.busy), 0);

`ifdef MICROSEQ_WDOG_EN
      // Long CONT chain: the 64th EXEC (cycle 130) exit trips the watchdog
      begin
         int n;
         issue(8'h80);
         n = 4;
         while (!wdog_trip && n < 300) begin
            tick();
            n++;
         end
         chk("wdog_cycle", 32'(n), 131);
         chk("wdog_busy", 32'(bus.busy), 0);
         chk("wdog_ctrl", 32'(bus.ctrl_signals), 0);
         tick();
         chk("wdog_pulse", 32'(wdog_trip), 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
